func_unit_arb: RTL
==================

FUNC_UNIT_ARB -- requirements
Module: func_unit_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the function unit; legal range 2..8.
REQ-002 Parameter W, default 8, operand and result width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port req  input  NREQ  per-requester request; requester holds it high until it sees its gnt bit.
REQ-006 Port op  input  NREQ  per-requester operation select: 0 = sum, 1 = double.
REQ-007 Port x  input  NREQ*W  packed first operands; requester i owns bits [i*W +: W].
REQ-008 Port y  input  NREQ*W  packed second operands; same packing as x; ignored for double.
REQ-009 Port gnt  output  NREQ  one-hot, one-cycle acceptance pulse.
REQ-010 Port res_valid  output  1  result available.
REQ-011 Port res  output  W  result value.
REQ-012 Port res_id  output  $clog2(NREQ)  index of the requester that owns res.
REQ-013 Port res_ready  input  1  consumer accepts the result.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and HOLD.
REQ-015 IDLE with any req bit high: on the next edge, latch that requester's op/x/y and index, drive gnt one-hot for exactly one cycle, and go to CALC.
REQ-016 IDLE with no req bit high: stay in IDLE with gnt = 0.
REQ-017 Arbitration SHALL be round-robin:
- search starts at rr_ptr and wraps from NREQ-1 to 0;
- rr_ptr becomes granted index + 1, modulo NREQ;
- rr_ptr reset value is 0.
REQ-018 CALC SHALL last exactly one cycle, register the result, set res_valid = 1 and go to HOLD.
- Latency from req sampled to res_valid high is 2 cycles.
REQ-019 Sum result SHALL be (x + y) mod 2^W; the carry is discarded.
REQ-020 Double result SHALL be (x << 1) mod 2^W; the MSB of x is discarded.
REQ-021 HOLD: res, res_id and res_valid SHALL stay stable until res_ready is sampled high; then clear res_valid and go to IDLE.
REQ-022 No grant SHALL be issued in CALC or HOLD.
- A req that stays high in those states waits.
- A newly rising req in those states also waits.
REQ-023 res_ready high while res_valid is low SHALL have no effect.
REQ-024 Changes to req, op, x or y of a non-granted requester while in CALC or HOLD SHALL have no effect on the in-flight result.

Reset
REQ-025 Asserting rst SHALL immediately force the following values, including mid-CALC or mid-HOLD:
- state = IDLE, rr_ptr = 0;
- gnt = 0, res_valid = 0, res = 0, res_id = 0.
REQ-026 An in-flight result SHALL be discarded on reset and SHALL NOT reappear after reset deasserts.
REQ-027 The first grant after reset deassertion SHALL occur no earlier than the first rising edge at which rst is low.

Configuration
REQ-028 The macro FUNC_UNIT_ARB_STATS_EN SHALL control an optional statistics feature.
- Defined: add output stat_ops (16 bits), which increments on every gnt and saturates at 16'hFFFF.
- Defined: add output stat_stall (16 bits), which increments on every cycle in HOLD with res_ready low and saturates at 16'hFFFF.
- Defined: both counters reset to 0.
- Undefined: neither port nor their logic exists, and all other behaviour is identical.

Structure
REQ-029 The op encodings (OP_SUM = 0, OP_DOUBLE = 1) and the FSM state encodings SHALL live in package func_unit_pkg.
REQ-030 The sum/double datapath SHALL be a separate combinational sub-module, func_unit, with ports op, x, y and res, W-parameterised.
- func_unit_arb instantiates func_unit once.

Verification
REQ-031 Single request: req[0]=1, op=0, x=1, y=2.
- Required: gnt=4'b0001 for 1 cycle.
- Required: res_valid two cycles after req is sampled, with res=3 and res_id=0.
REQ-032 Wrap and truncation: op=0, x=8'hFF, y=8'h02 gives res=8'h01; op=1, x=8'h81 gives res=8'h02.
REQ-033 Fairness: req=4'b1111 held high, res_ready=1.
- Required grant order: 0,1,2,3,0.
- Required: each grant is followed by exactly one result with the matching res_id.
REQ-034 Back-pressure: res_ready=0 for 5 cycles in HOLD.
- Required: res, res_id and res_valid stable throughout, and no gnt.
- If stats are enabled: stat_stall=5.
- After res_ready=1: next grant 2 cycles later (HOLD->IDLE, then grant).
REQ-035 Reset mid-operation: assert rst during CALC.
- Required: res_valid=0 and gnt=0 immediately.
- After release with req[2]=1: the first grant goes to index 2 (rr_ptr=0 search), and no stale result appears.

Source files
------------

// File: rtl/func_unit_pkg.sv
// ============================================================================
// Module   : func_unit_pkg
// Brief    : Shared op and FSM state encodings for the function-unit arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package func_unit_pkg;

    localparam logic OP_SUM    = 1'b0;
    localparam logic OP_DOUBLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/func_unit.sv
// ============================================================================
// Module   : func_unit
// Brief    : Combinational sum/double datapath; results wrap modulo 2^W.
// Revision : 1.0
// ============================================================================
`default_nettype none

module func_unit
    import func_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] res
);

    always_comb begin
        res = x + y;
        if (op == OP_DOUBLE) begin
            res = {x[W-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/func_unit_arb.sv
// ============================================================================
// Module   : func_unit_arb
// Brief    : Round-robin arbiter sharing one sum/double unit among NREQ
//            requesters. Optional counters under FUNC_UNIT_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module func_unit_arb
    import func_unit_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          op,
    input  logic [NREQ*W-1:0]        x,
    input  logic [NREQ*W-1:0]        y,
    output logic [NREQ-1:0]          gnt,
    output logic                     res_valid,
    output logic [W-1:0]             res,
    output logic [$clog2(NREQ)-1:0]  res_id,
    input  logic                     res_ready
`ifdef FUNC_UNIT_ARB_STATS_EN
    ,
    output logic [15:0]              stat_ops,
    output logic [15:0]              stat_stall
`endif
);

    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_win_idx;
    logic [NREQ-1:0] w_gnt_vec;
    logic            w_any_req;
    logic            w_grant_fire;
    int              w_cand;

    logic            r_op;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [IW-1:0]   r_id;
    logic [NREQ-1:0] r_gnt;
    logic            r_res_valid;
    logic [W-1:0]    r_res;
    logic [IW-1:0]   r_res_id;
    logic [W-1:0]    w_fu_res;

    assign w_any_req    = |req;
    assign w_grant_fire = (r_state == IDLE) && w_any_req;

    // Walk downward so the requester closest to r_rr_ptr is the last writer.
    always_comb begin
        w_cand    = 0;
        w_win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_cand = int'(r_rr_ptr) + i;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (req[IW'(w_cand)]) begin
                w_win_idx = IW'(w_cand);
            end
        end
    end

    always_comb begin
        w_gnt_vec            = '0;
        w_gnt_vec[w_win_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = CALC;
            CALC:    w_next_state = HOLD;
            HOLD:    if (res_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operands are captured at grant time so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_op        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_id        <= '0;
            r_gnt       <= '0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
            r_res_id    <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt    <= w_gnt_vec;
                        r_id     <= w_win_idx;
                        r_op     <= op[w_win_idx];
                        r_x      <= x[w_win_idx*W +: W];
                        r_y      <= y[w_win_idx*W +: W];
                        r_rr_ptr <= (w_win_idx == IW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
                    end
                end
                CALC: begin
                    r_res       <= w_fu_res;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                end
                HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    func_unit #(
        .W (W)
    ) u_func_unit (
        .op  (r_op),
        .x   (r_x),
        .y   (r_y),
        .res (w_fu_res)
    );

    assign gnt       = r_gnt;
    assign res_valid = r_res_valid;
    assign res       = r_res;
    assign res_id    = r_res_id;

`ifdef FUNC_UNIT_ARB_STATS_EN
    logic [15:0] r_stat_ops;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_grant_fire && (r_stat_ops != 16'hFFFF)) begin
                r_stat_ops <= r_stat_ops + 16'd1;
            end
            if ((r_state == HOLD) && !res_ready && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_ops   = r_stat_ops;
    assign stat_stall = r_stat_stall;
`else
    logic w_unused;
    assign w_unused = w_grant_fire;
`endif

endmodule

`default_nettype wire
